// File: rtl/alu_ctrl_pkg.sv
// Shared types for the RV32 ALU control decoder: ALU op codes, opcode constants, control bundle.
// Optional M-extension decode is enabled by defining ALU_CTRL_MEXT_EN.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpSll = 4'd2,
        OpSlt = 4'd3,
        OpXor = 4'd4,
        OpSrl = 4'd5,
        OpSra = 4'd6,
        OpOr  = 4'd7,
        OpAnd = 4'd8,
        OpEq  = 4'd9,
        OpNe  = 4'd10,
        OpLt  = 4'd11,
        OpGe  = 4'd12,
        OpMul = 4'd13,
        OpDiv = 4'd14,
        OpRem = 4'd15
    } alu_op_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mext = 7'b0000001;

    typedef struct packed {
        logic    alu_src;
        logic    jal;
        logic    is_signed;
        logic    branch;
        alu_op_e op;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode_if.sv
// Decode request/response bundle: instruction word in, control bundle out.
interface alu_ctrl_decode_if ();

    logic [31:0]         inst;
    alu_ctrl_pkg::ctrl_t ctrl;

    modport master (output inst, input ctrl);
    modport slave  (input inst, output ctrl);

endinterface

// File: rtl/alu_ctrl_dec_comb.sv
// Purely combinational RV32 decode to ALU control; M-extension decode when ALU_CTRL_MEXT_EN is
// defined, otherwise every funct7=0000001 OP word is illegal.
module alu_ctrl_dec_comb
    import alu_ctrl_pkg::*;
(
    alu_ctrl_decode_if.slave dec_if
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    ctrl_t      c;
    logic       ill;

    assign opcode = dec_if.inst[6:0];
    assign funct3 = dec_if.inst[14:12];
    assign funct7 = dec_if.inst[31:25];

    always_comb begin
        c   = '0;
        ill = 1'b0;
        case (opcode)
            OpcOp: begin
                if (funct7 == F7Base) begin
                    case (funct3)
                        3'd0: c.op = OpAdd;
                        3'd1: c.op = OpSll;
                        3'd2: begin c.op = OpSlt; c.is_signed = 1'b1; end
                        3'd3: c.op = OpSlt;
                        3'd4: c.op = OpXor;
                        3'd5: c.op = OpSrl;
                        3'd6: c.op = OpOr;
                        default: c.op = OpAnd;
                    endcase
                end else if (funct7 == F7Alt) begin
                    case (funct3)
                        3'd0:    c.op = OpSub;
                        3'd5:    c.op = OpSra;
                        default: ill = 1'b1;
                    endcase
`ifdef ALU_CTRL_MEXT_EN
                end else if (funct7 == F7Mext) begin
                    // MULH* produce the upper product half, which this ALU cannot return.
                    case (funct3)
                        3'd0:    c.op = OpMul;
                        3'd4:    begin c.op = OpDiv; c.is_signed = 1'b1; end
                        3'd5:    c.op = OpDiv;
                        3'd6:    begin c.op = OpRem; c.is_signed = 1'b1; end
                        3'd7:    c.op = OpRem;
                        default: ill = 1'b1;
                    endcase
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            OpcOpImm: begin
                c.alu_src = 1'b1;
                case (funct3)
                    3'd0: c.op = OpAdd;
                    3'd1: if (funct7 == F7Base) c.op = OpSll; else ill = 1'b1;
                    3'd2: begin c.op = OpSlt; c.is_signed = 1'b1; end
                    3'd3: c.op = OpSlt;
                    3'd4: c.op = OpXor;
                    3'd5: begin
                        if (funct7 == F7Base)     c.op = OpSrl;
                        else if (funct7 == F7Alt) c.op = OpSra;
                        else                      ill = 1'b1;
                    end
                    3'd6: c.op = OpOr;
                    default: c.op = OpAnd;
                endcase
            end
            OpcBranch: begin
                c.branch = 1'b1;
                case (funct3)
                    3'd0:    begin c.op = OpEq; c.is_signed = 1'b1; end
                    3'd1:    begin c.op = OpNe; c.is_signed = 1'b1; end
                    3'd4:    begin c.op = OpLt; c.is_signed = 1'b1; end
                    3'd5:    begin c.op = OpGe; c.is_signed = 1'b1; end
                    3'd6:    c.op = OpLt;
                    3'd7:    c.op = OpGe;
                    default: ill = 1'b1;
                endcase
            end
            OpcJal: c.jal = 1'b1;
            OpcJalr: begin
                c.jal     = 1'b1;
                c.alu_src = 1'b1;
                if (funct3 != 3'd0) ill = 1'b1;
            end
            OpcLoad: begin
                c.alu_src = 1'b1;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ill = 1'b1;
            end
            OpcStore: begin
                c.alu_src = 1'b1;
                if (funct3 > 3'd2) ill = 1'b1;
            end
            OpcLui, OpcAuipc: c.alu_src = 1'b1;
            default: ill = 1'b1;
        endcase

        if (ill) begin
            c         = '0;
            c.illegal = 1'b1;
        end
        dec_if.ctrl = c;
    end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Valid/ready decode stage: one result register plus saturating illegal-word counter.
// Decode itself lives in alu_ctrl_dec_comb (M-extension via ALU_CTRL_MEXT_EN).
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_inst,
    input  logic        io_flush,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic        io_out_ctrlALUSrc,
    output logic        io_out_ctrlJAL,
    output logic        io_out_ctrlSigned,
    output logic        io_out_ctrlBranch,
    output logic [3:0]  io_out_ctrlOP,
    output logic        io_out_illegal,
    output logic [15:0] io_illegal_count
);

    logic        valid_q, valid_d;
    ctrl_t       bundle_q, bundle_d;
    logic [15:0] count_q, count_d;
    logic        accept;

    alu_ctrl_decode_if dec_if ();

    assign dec_if.inst = io_in_inst;

    alu_ctrl_dec_comb u_dec_comb (
        .dec_if (dec_if)
    );

    always_comb begin
        io_in_ready = !io_flush && (!valid_q || io_out_ready);
        accept      = io_in_valid && io_in_ready;

        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (io_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec_if.ctrl;
        end else if (io_out_ready) begin
            valid_d = 1'b0;
        end

        count_d = count_q;
        if (accept && dec_if.ctrl.illegal && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            count_q  <= count_d;
        end
    end

    assign io_out_valid      = valid_q;
    assign io_out_ctrlALUSrc = bundle_q.alu_src;
    assign io_out_ctrlJAL    = bundle_q.jal;
    assign io_out_ctrlSigned = bundle_q.is_signed;
    assign io_out_ctrlBranch = bundle_q.branch;
    assign io_out_ctrlOP     = bundle_q.op;
    assign io_out_illegal    = bundle_q.illegal;
    assign io_illegal_count  = count_q;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed bench for alu_ctrl_decode: vector table plus handshake, flush, reset and saturation
// sequences. Expectations follow ALU_CTRL_MEXT_EN when it is defined.
module tb_alu_ctrl_decode;
    import alu_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        o_src, o_jal, o_sgn, o_br, o_ill;
    logic [3:0]  o_op;
    logic [15:0] ill_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clock = ~clock;

    alu_ctrl_decode_if tb_if ();

    assign tb_if.ctrl = ctrl_t'({o_src, o_jal, o_sgn, o_br, o_op, o_ill});

    alu_ctrl_decode dut (
        .clock             (clock),
        .reset             (reset),
        .io_in_valid       (in_valid),
        .io_in_ready       (in_ready),
        .io_in_inst        (tb_if.inst),
        .io_flush          (flush),
        .io_out_valid      (out_valid),
        .io_out_ready      (out_ready),
        .io_out_ctrlALUSrc (o_src),
        .io_out_ctrlJAL    (o_jal),
        .io_out_ctrlSigned (o_sgn),
        .io_out_ctrlBranch (o_br),
        .io_out_ctrlOP     (o_op),
        .io_out_illegal    (o_ill),
        .io_illegal_count  (ill_count)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        ctrl_t       exp;
    } vec_t;

    vec_t vecs[17];

    function automatic ctrl_t mk(logic src, logic jal, logic sgn, logic br, logic [3:0] op,
                                 logic ill);
        ctrl_t c;
        c.alu_src   = src;
        c.jal       = jal;
        c.is_signed = sgn;
        c.branch    = br;
        c.op        = alu_op_e'(op);
        c.illegal   = ill;
        return c;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(string name, ctrl_t exp);
        chk(name, 32'(tb_if.ctrl), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_t c_ill, c_add, c_addi;
        c_ill  = mk(0, 0, 0, 0, 0, 1);
        c_add  = mk(0, 0, 0, 0, 0, 0);
        c_addi = mk(1, 0, 0, 0, 0, 0);

        vecs[0]  = '{"add",   32'h003100B3, c_add};
        vecs[1]  = '{"addi",  32'h00500093, c_addi};
        vecs[2]  = '{"bltu",  32'h0020E463, mk(0, 0, 0, 1, 11, 0)};
        vecs[3]  = '{"jal",   32'h0000006F, mk(0, 1, 0, 0, 0, 0)};
        vecs[4]  = '{"sub",   32'h403100B3, mk(0, 0, 0, 0, 1, 0)};
        vecs[5]  = '{"sltu",  32'h003130B3, mk(0, 0, 0, 0, 3, 0)};
        vecs[6]  = '{"slt",   32'h003120B3, mk(0, 0, 1, 0, 3, 0)};
        vecs[7]  = '{"srai",  32'h40015093, mk(1, 0, 0, 0, 6, 0)};
        vecs[8]  = '{"beq",   32'h00208463, mk(0, 0, 1, 1, 9, 0)};
        vecs[9]  = '{"bge",   32'h0020D463, mk(0, 0, 1, 1, 12, 0)};
        vecs[10] = '{"lw",    32'h00012083, c_addi};
        vecs[11] = '{"sw",    32'h00112023, c_addi};
        vecs[12] = '{"lui",   32'h000010B7, c_addi};
        vecs[13] = '{"jalr",  32'h000080E7, mk(1, 1, 0, 0, 0, 0)};
        vecs[14] = '{"br_f3", 32'h0020A463, c_ill};
`ifdef ALU_CTRL_MEXT_EN
        vecs[15] = '{"mul",   32'h023100B3, mk(0, 0, 0, 0, 13, 0)};
        vecs[16] = '{"div",   32'h0231C0B3, mk(0, 0, 1, 0, 14, 0)};
`else
        vecs[15] = '{"mul",   32'h023100B3, c_ill};
        vecs[16] = '{"div",   32'h0231C0B3, c_ill};
`endif

        // Reset with a word on offer: the word must be dropped.
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        tb_if.inst = 32'h003100B3;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk_ctrl("rst_ctrl", mk(0, 0, 0, 0, 0, 0));
        chk("rst_count", 32'(ill_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rst_dropped", 32'(out_valid), 32'd0);

        // Three all-ones words, back to back.
        for (int i = 0; i < 3; i++) begin
            tb_if.inst = 32'hFFFFFFFF;
            in_valid   = 1'b1;
            tick();
            chk("ff_valid", 32'(out_valid), 32'd1);
            chk_ctrl("ff_ctrl", c_ill);
            chk("ff_count", 32'(ill_count), 32'(i + 1));
        end
        exp_cnt  = 3;
        in_valid = 1'b0;
        tick();
        chk("ff_drain", 32'(out_valid), 32'd0);

        // Vector table, one word per cycle.
        for (int i = 0; i < 17; i++) begin
            tb_if.inst = vecs[i].inst;
            in_valid   = 1'b1;
            tick();
            in_valid = 1'b0;
            if (vecs[i].exp.illegal) exp_cnt++;
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk_ctrl(vecs[i].name, vecs[i].exp);
            chk({vecs[i].name, "_count"}, 32'(ill_count), 32'(exp_cnt));
        end
        tick();
        chk("tbl_drain", 32'(out_valid), 32'd0);

        // Stall: bundle held, no accept, then drain plus accept in one cycle.
        tb_if.inst = 32'h003100B3;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick();
        chk("stall_valid0", 32'(out_valid), 32'd1);
        tb_if.inst = 32'h00500093;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk_ctrl("stall_hold", c_add);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk_ctrl("drain_next", c_addi);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush while holding a bundle and offering a new word.
        tb_if.inst = 32'h403100B3;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick();
        chk("fl_valid0", 32'(out_valid), 32'd1);
        flush      = 1'b1;
        tb_if.inst = 32'h0020E463;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("fl_not_decoded", 32'(out_valid), 32'd0);
        chk("fl_count", 32'(ill_count), 32'(exp_cnt));

        // Reset during a stall discards the held bundle.
        tb_if.inst = 32'h00500093;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rs_valid0", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk_ctrl("rs_ctrl", mk(0, 0, 0, 0, 0, 0));
        chk("rs_count", 32'(ill_count), 32'd0);

        // Counter saturation at 0xFFFF.
        out_ready  = 1'b1;
        tb_if.inst = 32'hFFFFFFFF;
        in_valid   = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        chk("sat_fffe", 32'(ill_count), 32'h0000FFFE);
        tick();
        chk("sat_ffff", 32'(ill_count), 32'h0000FFFF);
        tick();
        tick();
        chk("sat_hold", 32'(ill_count), 32'h0000FFFF);
        chk_ctrl("sat_ctrl", c_ill);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode.md
ALU_CTRL_DECODE -- requirements
Module: alu_ctrl_decode

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port io_in_valid, input, 1, instruction word offered.
REQ-004 SHALL have port io_in_ready, output, 1, block accepts the word this cycle.
REQ-005 SHALL have port io_in_inst, input, 32, RV32 instruction word.
REQ-006 SHALL have port io_flush, input, 1, discard the held decode result.
REQ-007 SHALL have port io_out_valid, output, 1, decoded bundle valid.
REQ-008 SHALL have port io_out_ready, input, 1, downstream ALU accepts the bundle.
REQ-009 SHALL have ports io_out_ctrlALUSrc, io_out_ctrlJAL, io_out_ctrlSigned and io_out_ctrlBranch, each output, 1: immediate operand, jump-link, signed compare/divide, conditional branch.
REQ-010 SHALL have port io_out_ctrlOP, output, 4, ALU operation code.
REQ-011 SHALL have ports io_out_illegal, output, 1, unsupported encoding; and io_illegal_count, output, 16, saturating count of illegal words accepted.

Function
REQ-012 SHALL drive io_in_ready = !io_flush && (!io_out_valid || io_out_ready).
REQ-013 SHALL register the decode of io_in_inst when io_in_valid && io_in_ready, and raise io_out_valid the next cycle (latency 1).
REQ-014 SHALL hold all io_out_* fields and io_out_valid stable while io_out_valid && !io_out_ready.
REQ-015 SHALL clear io_out_valid on the cycle after io_out_valid && io_out_ready if no new word is accepted; back-to-back accept plus drain SHALL give one word per cycle.
REQ-016 SHALL give io_flush priority: next cycle io_out_valid=0, and no word is accepted in the flush cycle.
REQ-017 SHALL use ctrlOP codes ADD=0, SUB=1, SLL=2, SLT=3, XOR=4, SRL=5, SRA=6, OR=7, AND=8, EQ=9, NE=10, LT=11, GE=12, MUL=13, DIV=14, REM=15.
REQ-018 SHALL decode OP/OP-IMM to ADD..AND; ctrlSigned=1 for SLT/SLTI and 0 for SLTU/SLTIU; ctrlALUSrc=1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR.
REQ-019 SHALL decode BRANCH to ctrlBranch=1 with EQ/NE/LT/GE; ctrlSigned=0 for BLTU/BGEU, else 1.
REQ-020 SHALL decode JAL/JALR to ctrlJAL=1, ctrlOP=ADD; LOAD/STORE/LUI/AUIPC to ctrlOP=ADD.
REQ-021 SHALL flag any other opcode, funct3 or funct7 as io_out_illegal=1 with every other control field 0.
REQ-022 SHALL increment io_illegal_count by 1 per accepted illegal word, saturating at 0xFFFF; flushed words still count.

Reset
REQ-023 SHALL, on reset, clear io_out_valid, all io_out_* fields and io_illegal_count to 0; a word offered during reset SHALL be dropped.
REQ-024 SHALL let reset asserted mid-stall discard the held bundle with no output handshake.

Configuration
REQ-025 SHALL, with ALU_CTRL_MEXT_EN defined, decode funct7=0000001 in OP: MUL to MUL, DIV/DIVU to DIV, REM/REMU to REM, ctrlSigned=1 for signed forms; MULH/MULHSU/MULHU SHALL be illegal.
REQ-026 SHALL, without ALU_CTRL_MEXT_EN, flag every funct7=0000001 OP word as illegal.

Structure
REQ-027 SHALL place the ctrlOP enumeration, RV32 opcode constants and the control-bundle struct in the shared package alu_ctrl_pkg.
REQ-028 SHALL split the combinational decode into the sub-module alu_ctrl_dec_comb; alu_ctrl_decode holds only the handshake register and counter.

Verification
REQ-029 SHALL cover ADD 0x003100B3 with out_ready=1, which gives out_valid one cycle later with OP=0, ALUSrc=0, illegal=0; ADDI 0x00500093 gives OP=0, ALUSrc=1.
REQ-030 SHALL cover BLTU 0x0020E463, which gives Branch=1, OP=11, Signed=0; JAL 0x0000006F gives JAL=1, OP=0.
REQ-031 SHALL cover 0xFFFFFFFF three times, which gives illegal=1 each time and illegal_count=3; with the count preloaded to 0xFFFF it stays 0xFFFF.
REQ-032 SHALL cover out_ready=0 for 4 cycles after accept, with in_ready=0 and the bundle unchanged; out_ready=1 then drains it, and a word accepted in the same cycle appears next cycle.
REQ-033 SHALL cover flush with out_valid=1 and in_valid=1, which gives in_ready=0 and out_valid=0 next cycle, with the offered word not decoded.
REQ-034 SHALL cover MUL 0x023100B3, which gives OP=13 with ALU_CTRL_MEXT_EN defined and illegal=1 without it.
